calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL take one parameter: TIMEOUT, default 8'd200, the maximum number of cycles it waits for alu_done.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock, rising-edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port key_trig, input, 1 bit: one-cycle pulse per debounced key press.
REQ-005 The block SHALL have port key_value, input, 4 bits: key code, valid when key_trig=1. Codes: 0-9 digit, A add, B subtract, C clear, E equals; D and F unused.
REQ-006 The block SHALL have port operand, input, 8 bits: current entry as two's complement.
REQ-007 The block SHALL have port over_range, input, 1 bit: 1 means the entry magnitude exceeds 127.
REQ-008 The block SHALL have port alu_done, input, 1 bit: ALU completion pulse.
REQ-009 The block SHALL have port alu_result, input, 8 bits: ALU result, valid with alu_done.
REQ-010 The block SHALL have port alu_ovf, input, 1 bit: ALU overflow, valid with alu_done.
REQ-011 The block SHALL have port entry_clr, output, 1 bit: one-cycle pulse that clears the entry module.
REQ-012 The block SHALL have ports op_a and op_b, outputs, 8 bits each: the latched operands.
REQ-013 The block SHALL have port op_sel, output, 1 bit: 0 add, 1 subtract.
REQ-014 The block SHALL have port alu_start, output, 1 bit: one-cycle ALU launch pulse.
REQ-015 The block SHALL have port result, output, 8 bits: the displayed result.
REQ-016 The block SHALL have port error, output, 1 bit: error indicator.
REQ-017 The block SHALL have port state, output, 3 bits: state code. S_A=0, S_B=1, S_EXEC=2, S_WAIT=3, S_SHOW=4, S_ERR=5.

Function
REQ-018 All outputs SHALL be registered, and all transitions SHALL occur on the rising clock edge.
REQ-019 In S_A, on key A/B: if over_range=1, go to S_ERR; otherwise latch op_a=operand and op_sel (A→0, B→1), pulse entry_clr the next cycle, and go to S_B.
REQ-020 In S_B, on key A/B: update op_sel only and stay in S_B.
REQ-021 In S_B, on key E: if over_range=1, go to S_ERR; otherwise latch op_b=operand and go to S_EXEC.
REQ-022 In S_EXEC, assert alu_start for exactly one cycle, clear the wait counter, and go to S_WAIT.
REQ-023 In S_WAIT, the 8-bit counter SHALL increment each cycle.
REQ-024 In S_WAIT, on alu_done: latch result=alu_result; if alu_ovf=1, go to S_ERR; otherwise pulse entry_clr and go to S_SHOW.
REQ-025 In S_WAIT, if the counter reaches TIMEOUT with no alu_done, go to S_ERR.
REQ-026 alu_done arriving in the same cycle the counter reaches TIMEOUT SHALL be accepted as completion, not timeout.
REQ-027 In S_SHOW, result SHALL be held.
REQ-028 In S_SHOW, key A/B: set op_a=result and op_sel, pulse entry_clr, and go to S_B (chained operation).
REQ-029 In S_SHOW, a digit key SHALL go to S_A with no entry_clr; the digit is retained by the entry module.
REQ-030 In S_ERR, error=1 and result=0; only key C exits.
REQ-031 Key C in any state SHALL go to S_A, set op_a=op_b=result=0, error=0, op_sel=0, and pulse entry_clr.
REQ-032 Key C SHALL take priority over a simultaneous alu_done or timeout.
REQ-033 The following SHALL be ignored: keys D/F in all states; digit keys outside S_SHOW; all keys except C in S_EXEC and S_WAIT; alu_done outside S_WAIT.
REQ-034 No output other than entry_clr and alu_start SHALL pulse; each pulse SHALL be exactly one cycle wide.

Reset
REQ-035 While reset=1, the block SHALL immediately enter S_A with all outputs 0 and the wait counter 0, independent of clock.
REQ-036 Reset asserted mid-operation (including S_WAIT) SHALL abandon the operation; a late alu_done after reset release SHALL be ignored.

Verification
REQ-037 Scenario: operand=25, key A, operand=100, key E, alu_done with result 125, ovf=0 → op_a=25, op_b=100, op_sel=0, alu_start is 1 cycle, result=125, state=4, entry_clr pulses twice.
REQ-038 Scenario: operand=-5, key B, operand=10, key E, result=-15 → op_sel=1, result=8'hF1. Then key A → op_a=8'hF1, state=1.
REQ-039 Scenario: over_range=1 with key A in S_A → state=5, error=1. Key E is then ignored; key C → state=0, error=0, entry_clr pulses.
REQ-040 Scenario: no alu_done for TIMEOUT cycles → S_ERR exactly at count TIMEOUT. A separate run with alu_done on that same cycle → S_SHOW.
REQ-041 Scenario: key C in the same cycle as alu_done in S_WAIT → state=0, result=0.
REQ-042 Scenario: reset pulse asserted in S_WAIT, then alu_done two cycles after reset release → state remains 0 and all outputs remain 0.

Source files
------------

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//   Control sequencer for a two-operand add/subtract calculator. It collects
//   operand A and the operation from the key stream, then collects operand B.
//   After that it launches the ALU, waits a bounded time for completion and
//   shows the result. It also handles chained operations, errors and clear.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   key_trig    in   one-cycle pulse per debounced key press
//   key_value   in   [3:0] key code (0-9 digit, A add, B sub, C clear, E equals)
//   operand     in   [7:0] current entry, two's complement
//   over_range  in   entry magnitude exceeds 127
//   alu_done    in   ALU completion pulse
//   alu_result  in   [7:0] ALU result, valid with alu_done
//   alu_ovf     in   ALU overflow, valid with alu_done
//   entry_clr   out  one-cycle pulse that clears the entry module
//   op_a, op_b  out  [7:0] latched operands
//   op_sel      out  0 add, 1 subtract
//   alu_start   out  one-cycle ALU launch pulse
//   result      out  [7:0] displayed result
//   error       out  error indicator
//   state       out  [2:0] state code (A=0 B=1 EXEC=2 WAIT=3 SHOW=4 ERR=5)
//
// ALU handshake: alu_start is a single-cycle request. It is high exactly
// while state reads S_EXEC. The ALU answers with a single-cycle alu_done,
// and alu_result/alu_ovf are valid in that cycle. The sequencer samples
// alu_done only in S_WAIT. A response that arrives in any other state
// (for example after clear or reset) is dropped.
// ---------------------------------------------------------------------------
module calc_sequencer #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_trig,
    input  logic [3:0] key_value,
    input  logic [7:0] operand,
    input  logic       over_range,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    input  logic       alu_ovf,
    output logic       entry_clr,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_sel,
    output logic       alu_start,
    output logic [7:0] result,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_EXEC = 3'd2,
        S_WAIT = 3'd3,
        S_SHOW = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       op_sel_q, op_sel_d;
    logic [7:0] result_q, result_d;
    logic       error_q, error_d;
    logic       entry_clr_q, entry_clr_d;
    logic       alu_start_q, alu_start_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Key decode; every class is qualified by key_trig.
    logic key_op, key_sub, key_clr, key_eq, key_digit;

    always_comb begin
        key_op    = key_trig && ((key_value == 4'hA) || (key_value == 4'hB));
        key_sub   = (key_value == 4'hB);
        key_clr   = key_trig && (key_value == 4'hC);
        key_eq    = key_trig && (key_value == 4'hE);
        key_digit = key_trig && (key_value <= 4'd9);
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        result_d    = result_q;
        error_d     = error_q;
        entry_clr_d = 1'b0;
        alu_start_d = 1'b0;
        wait_cnt_d  = wait_cnt_q;

        if (key_clr) begin
            // Clear wins over everything, including a completing ALU.
            state_d     = S_A;
            op_a_d      = 8'd0;
            op_b_d      = 8'd0;
            op_sel_d    = 1'b0;
            result_d    = 8'd0;
            error_d     = 1'b0;
            entry_clr_d = 1'b1;
            wait_cnt_d  = 8'd0;
        end else begin
            case (state_q)
                S_A: begin
                    if (key_op) begin
                        if (over_range) begin
                            state_d  = S_ERR;
                            error_d  = 1'b1;
                            result_d = 8'd0;
                        end else begin
                            op_a_d      = operand;
                            op_sel_d    = key_sub;
                            entry_clr_d = 1'b1;
                            state_d     = S_B;
                        end
                    end
                end
                S_B: begin
                    if (key_op) begin
                        op_sel_d = key_sub;
                    end else if (key_eq) begin
                        if (over_range) begin
                            state_d  = S_ERR;
                            error_d  = 1'b1;
                            result_d = 8'd0;
                        end else begin
                            op_b_d      = operand;
                            state_d     = S_EXEC;
                            // Registered, so the pulse lines up with S_EXEC.
                            alu_start_d = 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (alu_done) begin
                        // Completion is checked before the timeout, so
                        // alu_done in the final wait cycle counts as a
                        // completion.
                        if (alu_ovf) begin
                            state_d  = S_ERR;
                            error_d  = 1'b1;
                            result_d = 8'd0;
                        end else begin
                            result_d    = alu_result;
                            entry_clr_d = 1'b1;
                            state_d     = S_SHOW;
                        end
                    end else if (wait_cnt_q == (TIMEOUT - 8'd1)) begin
                        // The counter reaches TIMEOUT on this edge.
                        state_d  = S_ERR;
                        error_d  = 1'b1;
                        result_d = 8'd0;
                    end
                end
                S_SHOW: begin
                    if (key_op) begin
                        op_a_d      = result_q;
                        op_sel_d    = key_sub;
                        entry_clr_d = 1'b1;
                        state_d     = S_B;
                    end else if (key_digit) begin
                        // The entry module keeps this digit as the start of
                        // a new operand, so no clear is sent.
                        state_d = S_A;
                    end
                end
                S_ERR: begin
                    error_d  = 1'b1;
                    result_d = 8'd0;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_A;
            op_a_q      <= 8'd0;
            op_b_q      <= 8'd0;
            op_sel_q    <= 1'b0;
            result_q    <= 8'd0;
            error_q     <= 1'b0;
            entry_clr_q <= 1'b0;
            alu_start_q <= 1'b0;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            result_q    <= result_d;
            error_q     <= error_d;
            entry_clr_q <= entry_clr_d;
            alu_start_q <= alu_start_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign entry_clr = entry_clr_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_sel    = op_sel_q;
    assign alu_start = alu_start_q;
    assign result    = result_q;
    assign error     = error_q;
    assign state     = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
//   Directed bench for calc_sequencer. Each task runs one scenario and
//   checks the outputs against hand-computed values. Inputs change 1 time
//   unit after a rising edge. Outputs are read at that same point, after
//   the edge that registered them. Pulse widths are counted on falling
//   edges.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;

    localparam logic [7:0] TMO = 8'd200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_trig = 1'b0;
    logic [3:0] key_value = 4'h0;
    logic [7:0] operand = 8'd0;
    logic       over_range = 1'b0;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'd0;
    logic       alu_ovf = 1'b0;
    logic       entry_clr;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_sel;
    logic       alu_start;
    logic [7:0] result;
    logic       error;
    logic [2:0] state;

    int n_cmp = 0;
    int n_fail = 0;
    int clr_pulses = 0;
    int start_pulses = 0;

    calc_sequencer #(.TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_trig   (key_trig),
        .key_value  (key_value),
        .operand    (operand),
        .over_range (over_range),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .entry_clr  (entry_clr),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sel     (op_sel),
        .alu_start  (alu_start),
        .result     (result),
        .error      (error),
        .state      (state)
    );

    // Clock and pulse-width monitor.
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (entry_clr === 1'b1) clr_pulses++;
        if (alu_start === 1'b1) start_pulses++;
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_trig  = 1'b1;
        key_value = k;
        tick();
        key_trig  = 1'b0;
        key_value = 4'h0;
    endtask

    task automatic do_reset();
        key_trig = 1'b0; alu_done = 1'b0; alu_ovf = 1'b0; over_range = 1'b0;
        operand = 8'd0; alu_result = 8'd0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic finish_alu(input logic [7:0] r, input logic ovf);
        alu_done = 1'b1; alu_result = r; alu_ovf = ovf;
        tick();
        alu_done = 1'b0; alu_result = 8'd0; alu_ovf = 1'b0;
    endtask

    // From S_A: enter A, op key, B, equals, then one edge into S_WAIT.
    task automatic go_wait(input logic [7:0] a, input logic [7:0] b, input logic sub);
        operand = a;
        press(sub ? 4'hB : 4'hA);
        operand = b;
        press(4'hE);
        tick();
        n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL go_wait_state got=%0d exp=3", state); end
    endtask

    // Scenarios.
    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++; if ({entry_clr, op_a, op_b, op_sel, alu_start, result, error} !== 28'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", {entry_clr, op_a, op_b, op_sel, alu_start, result, error}); end
        do_reset();
        n_cmp++; if ({state, entry_clr, op_a, op_b, op_sel, alu_start, result, error} !== 31'd0) begin
            n_fail++; $display("FAIL reset_release got=%h exp=0", {state, entry_clr, op_a, op_b, op_sel, alu_start, result, error}); end
    endtask

    task automatic test_add();
        int clr0, st0;
        do_reset();
        clr0 = clr_pulses; st0 = start_pulses;
        operand = 8'd25;
        press(4'hA);
        n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL add_state_b got=%0d exp=1", state); end
        n_cmp++; if (op_a !== 8'd25) begin n_fail++; $display("FAIL add_op_a got=%0d exp=25", op_a); end
        n_cmp++; if (entry_clr !== 1'b1) begin n_fail++; $display("FAIL add_clr1 got=%b exp=1", entry_clr); end
        operand = 8'd100;
        press(4'hE);
        n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL add_state_exec got=%0d exp=2", state); end
        n_cmp++; if (op_b !== 8'd100) begin n_fail++; $display("FAIL add_op_b got=%0d exp=100", op_b); end
        n_cmp++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL add_start got=%b exp=1", alu_start); end
        tick();
        n_cmp++; if ({state, alu_start} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL add_wait got=%0d/%b exp=3/0", state, alu_start); end
        tick();
        tick();
        finish_alu(8'd125, 1'b0);
        n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL add_state_show got=%0d exp=4", state); end
        n_cmp++; if (result !== 8'd125) begin n_fail++; $display("FAIL add_result got=%0d exp=125", result); end
        n_cmp++; if (op_sel !== 1'b0) begin n_fail++; $display("FAIL add_op_sel got=%b exp=0", op_sel); end
        n_cmp++; if (entry_clr !== 1'b1) begin n_fail++; $display("FAIL add_clr2 got=%b exp=1", entry_clr); end
        tick();
        tick();
        n_cmp++; if ({state, result, entry_clr} !== {3'd4, 8'd125, 1'b0}) begin
            n_fail++; $display("FAIL add_show_hold got=%0d/%0d/%b exp=4/125/0", state, result, entry_clr); end
        n_cmp++; if (clr_pulses - clr0 !== 2) begin n_fail++; $display("FAIL add_clr_count got=%0d exp=2", clr_pulses - clr0); end
        n_cmp++; if (start_pulses - st0 !== 1) begin n_fail++; $display("FAIL add_start_count got=%0d exp=1", start_pulses - st0); end
    endtask

    task automatic test_sub_chain();
        do_reset();
        go_wait(8'hFB, 8'd10, 1'b1);
        n_cmp++; if ({op_a, op_b, op_sel} !== {8'hFB, 8'h0A, 1'b1}) begin
            n_fail++; $display("FAIL sub_ops got=%h/%h/%b exp=fb/0a/1", op_a, op_b, op_sel); end
        finish_alu(8'hF1, 1'b0);
        n_cmp++; if ({state, result} !== {3'd4, 8'hF1}) begin n_fail++; $display("FAIL sub_show got=%0d/%h exp=4/f1", state, result); end
        press(4'hA);
        n_cmp++; if ({state, op_a, op_sel, entry_clr} !== {3'd1, 8'hF1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL chain got=%0d/%h/%b/%b exp=1/f1/0/1", state, op_a, op_sel, entry_clr); end
        press(4'hB);
        n_cmp++; if ({state, op_a, op_sel, entry_clr} !== {3'd1, 8'hF1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL opsel_update got=%0d/%h/%b/%b exp=1/f1/1/0", state, op_a, op_sel, entry_clr); end
    endtask

    task automatic test_over_range();
        do_reset();
        over_range = 1'b1; operand = 8'd77;
        press(4'hA);
        n_cmp++; if ({state, error, result} !== {3'd5, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL ovr_err got=%0d/%b/%0d exp=5/1/0", state, error, result); end
        over_range = 1'b0;
        press(4'hE);
        press(4'hA);
        n_cmp++; if ({state, error} !== {3'd5, 1'b1}) begin n_fail++; $display("FAIL ovr_ignore got=%0d/%b exp=5/1", state, error); end
        press(4'hC);
        n_cmp++; if ({state, error, entry_clr} !== {3'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ovr_clear got=%0d/%b/%b exp=0/0/1", state, error, entry_clr); end
    endtask

    task automatic test_alu_ovf();
        do_reset();
        go_wait(8'd100, 8'd100, 1'b0);
        finish_alu(8'hC8, 1'b1);
        n_cmp++; if ({state, error, result} !== {3'd5, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL aluovf got=%0d/%b/%h exp=5/1/00", state, error, result); end
    endtask

    task automatic test_timeout();
        do_reset();
        go_wait(8'd3, 8'd4, 1'b0);
        for (int i = 0; i < int'(TMO) - 1; i++) tick();
        n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL tmo_last_wait got=%0d exp=3", state); end
        tick();
        n_cmp++; if ({state, error, result} !== {3'd5, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL tmo_err got=%0d/%b/%0d exp=5/1/0", state, error, result); end
        // Same cycle count, but alu_done lands in the final wait cycle.
        do_reset();
        go_wait(8'd3, 8'd4, 1'b0);
        for (int i = 0; i < int'(TMO) - 1; i++) tick();
        finish_alu(8'd7, 1'b0);
        n_cmp++; if ({state, error, result} !== {3'd4, 1'b0, 8'd7}) begin
            n_fail++; $display("FAIL tmo_done_edge got=%0d/%b/%0d exp=4/0/7", state, error, result); end
    endtask

    task automatic test_clear_priority();
        do_reset();
        go_wait(8'd25, 8'd100, 1'b0);
        finish_alu(8'd125, 1'b0);
        press(4'hA);
        operand = 8'd1;
        press(4'hE);
        tick();
        press(4'hB);
        n_cmp++; if ({state, result, op_sel} !== {3'd3, 8'd125, 1'b0}) begin
            n_fail++; $display("FAIL wait_ignore got=%0d/%0d/%b exp=3/125/0", state, result, op_sel); end
        alu_done = 1'b1; alu_result = 8'd126;
        press(4'hC);
        alu_done = 1'b0; alu_result = 8'd0;
        n_cmp++; if ({state, result, op_a, op_b, error, entry_clr} !== {3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL clr_prio got=%0d/%0d/%0d/%0d/%b/%b exp=0/0/0/0/0/1", state, result, op_a, op_b, error, entry_clr); end
    endtask

    task automatic test_ignored();
        int clr0;
        do_reset();
        clr0 = clr_pulses;
        press(4'h5); press(4'hD); press(4'hF); press(4'hE);
        alu_done = 1'b1; alu_result = 8'd9; tick(); alu_done = 1'b0;
        n_cmp++; if ({state, result, clr_pulses - clr0} !== {3'd0, 8'd0, 32'd0}) begin
            n_fail++; $display("FAIL ignore_s_a got=%0d/%0d/%0d exp=0/0/0", state, result, clr_pulses - clr0); end
        go_wait(8'd2, 8'd3, 1'b0);
        finish_alu(8'd5, 1'b0);
        tick();
        clr0 = clr_pulses;
        press(4'h7);
        tick();
        n_cmp++; if ({state, clr_pulses - clr0} !== {3'd0, 32'd0}) begin
            n_fail++; $display("FAIL show_digit got=%0d/%0d exp=0/0", state, clr_pulses - clr0); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        go_wait(8'd40, 8'd2, 1'b1);
        reset = 1'b1;
        #2;
        n_cmp++; if ({state, op_a, op_b, op_sel, error} !== {3'd0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL async_reset got=%0d/%0d/%0d/%b exp=0/0/0/0", state, op_a, op_b, op_sel); end
        tick();
        reset = 1'b0;
        tick();
        tick();
        finish_alu(8'd38, 1'b0);
        tick();
        n_cmp++; if ({state, entry_clr, op_a, op_b, op_sel, alu_start, result, error} !== 31'd0) begin
            n_fail++; $display("FAIL late_done got=%h exp=0", {state, entry_clr, op_a, op_b, op_sel, alu_start, result, error}); end
    endtask

    // Sequence and report.
    initial begin
        test_reset();
        test_add();
        test_sub_chain();
        test_over_range();
        test_alu_ovf();
        test_timeout();
        test_clear_priority();
        test_ignored();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
